// File: rtl/gmii_tx_pkg.sv
// Shared encodings and constants for the GMII transmit arbiter and its CRC datapath.
// Pure declarations: no logic, no latency, no flow control.
package gmii_tx_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_e;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam int unsigned MIN_FRAME   = 60;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
endpackage

// File: rtl/gmii_tx_arb_crc32_d8.sv
// Next-state CRC-32 for one reflected input byte, LSB of d processed first.
// Purely combinational, zero latency, no flow control.
module crc32_d8
    import gmii_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ d[i]) crc_out = (crc_out >> 1) ^ CRC_POLY;
            else                   crc_out = crc_out >> 1;
        end
    end
endmodule

// File: rtl/gmii_tx_arb.sv
// Arbitrates video/audio sources onto one GMII TX port, framing with preamble, pad, FCS, IFG.
// req->first preamble byte: 1 cycle; sources cannot be stalled, they must supply a byte on every ack.
module gmii_tx_arb
    import gmii_tx_pkg::*;
#(
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MAX_FRAME    = 1514,
    parameter bit          AUDIO_PRIO   = 1'b1
) (
    input  logic       clk125,
    input  logic       sys_rst,
    input  logic       vid_req,
    input  logic [7:0] vid_data,
    input  logic       vid_last,
    output logic       vid_gnt,
    output logic       vid_ack,
    input  logic       aud_req,
    input  logic [7:0] aud_data,
    input  logic       aud_last,
    output logic       aud_gnt,
    output logic       aud_ack,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       busy,
    output logic       trunc_err
);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 2);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [10:0] MIN_W    = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_W    = 11'(MAX_FRAME);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] bcnt_q, bcnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        vid_gnt_q, vid_gnt_d;
    logic        aud_gnt_q, aud_gnt_d;
    logic        last_aud_q, last_aud_d;
    logic        corrupt_q, corrupt_d;
    logic        trunc_q, trunc_d;

    logic        ack;
    logic [7:0]  in_dat;
    logic        in_last;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;
    logic [31:0] fcs_word;
    logic [10:0] bcnt_inc;
    logic        pick_vid;

    assign ack      = (state_q == ST_DATA) & (vid_gnt_q | aud_gnt_q);
    assign in_dat   = vid_gnt_q ? vid_data : aud_data;
    assign in_last  = vid_gnt_q ? vid_last : aud_last;
    assign crc_byte = (state_q == ST_PAD) ? 8'h00 : in_dat;
    assign fcs_word = corrupt_q ? crc_q : ~crc_q;
    assign bcnt_inc = bcnt_q + 11'd1;
    // Video wins a tie only in round-robin mode when audio had the previous grant.
    assign pick_vid = vid_req & (~aud_req | (~AUDIO_PRIO & last_aud_q));

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (crc_byte),
        .crc_out (crc_next)
    );

    // txd_q is loaded one edge ahead, so each state prepares the byte for the next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        crc_d      = crc_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        vid_gnt_d  = vid_gnt_q;
        aud_gnt_d  = aud_gnt_q;
        last_aud_d = last_aud_q;
        corrupt_d  = corrupt_q;
        trunc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                txd_d   = 8'h00;
                tx_en_d = 1'b0;
                if (vid_req | aud_req) begin
                    state_d    = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
                    cnt_d      = '0;
                    txd_d      = PRE_BYTE;
                    tx_en_d    = 1'b1;
                    vid_gnt_d  = pick_vid;
                    aud_gnt_d  = ~pick_vid;
                    last_aud_d = ~pick_vid;
                    corrupt_d  = 1'b0;
                end
            end
            ST_PRE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == PRE_LAST) state_d = ST_SFD;
            end
            ST_SFD: begin
                txd_d   = SFD_BYTE;
                crc_d   = CRC_INIT;
                bcnt_d  = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                txd_d  = in_dat;
                crc_d  = crc_next;
                bcnt_d = bcnt_inc;
                if (in_last) begin
                    cnt_d   = '0;
                    state_d = (bcnt_inc < MIN_W) ? ST_PAD : ST_FCS;
                end else if (bcnt_inc == MAX_W) begin
                    cnt_d     = '0;
                    state_d   = ST_FCS;
                    corrupt_d = 1'b1;
                    trunc_d   = 1'b1;
                end
            end
            ST_PAD: begin
                txd_d  = 8'h00;
                crc_d  = crc_next;
                bcnt_d = bcnt_inc;
                if (bcnt_inc == MIN_W) begin
                    cnt_d   = '0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                txd_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d = cnt_q + 8'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                txd_d     = 8'h00;
                tx_en_d   = 1'b0;
                vid_gnt_d = 1'b0;
                aud_gnt_d = 1'b0;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q == IFG_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            crc_q      <= CRC_INIT;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            vid_gnt_q  <= 1'b0;
            aud_gnt_q  <= 1'b0;
            last_aud_q <= 1'b1;
            corrupt_q  <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            vid_gnt_q  <= vid_gnt_d;
            aud_gnt_q  <= aud_gnt_d;
            last_aud_q <= last_aud_d;
            corrupt_q  <= corrupt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign vid_gnt   = vid_gnt_q;
    assign aud_gnt   = aud_gnt_q;
    assign vid_ack   = ack & vid_gnt_q;
    assign aud_ack   = ack & aud_gnt_q;
    assign txd       = txd_q;
    assign tx_en     = tx_en_q;
    assign busy      = (state_q != ST_IDLE);
    assign trunc_err = trunc_q;
endmodule

// File: tb/tb_gmii_tx_arb.sv
// Directed bench: two arbiter instances (audio-priority and round-robin) plus the CRC helper.
// Sources answer acks one byte per cycle; a wire monitor captures frames for checking.
module tb_gmii_tx_arb;
    import gmii_tx_pkg::*;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       sys_rst;
    logic       vid_req, vid_last, aud_req, aud_last;
    logic [7:0] vid_data, aud_data;
    logic       vid_gnt, vid_ack, aud_gnt, aud_ack;
    logic [7:0] txd;
    logic       tx_en, busy, trunc_err;

    logic       rr_vid_req, rr_aud_req;
    logic [7:0] rr_vid_data = 8'h11, rr_aud_data = 8'h22;
    logic       rr_vid_last = 1'b1, rr_aud_last = 1'b1;
    logic       rr_vid_gnt, rr_vid_ack, rr_aud_gnt, rr_aud_ack;
    logic [7:0] rr_txd;
    logic       rr_tx_en, rr_busy, rr_trunc;

    logic [31:0] c_in, c_out;
    logic [7:0]  c_d;

    gmii_tx_arb #(.IFG_BYTES(12), .PREAMBLE_LEN(7), .MAX_FRAME(1514), .AUDIO_PRIO(1'b1)) u_dut (
        .clk125(clk), .sys_rst(sys_rst),
        .vid_req(vid_req), .vid_data(vid_data), .vid_last(vid_last), .vid_gnt(vid_gnt), .vid_ack(vid_ack),
        .aud_req(aud_req), .aud_data(aud_data), .aud_last(aud_last), .aud_gnt(aud_gnt), .aud_ack(aud_ack),
        .txd(txd), .tx_en(tx_en), .busy(busy), .trunc_err(trunc_err)
    );

    gmii_tx_arb #(.IFG_BYTES(12), .PREAMBLE_LEN(7), .MAX_FRAME(1514), .AUDIO_PRIO(1'b0)) u_rr (
        .clk125(clk), .sys_rst(sys_rst),
        .vid_req(rr_vid_req), .vid_data(rr_vid_data), .vid_last(rr_vid_last), .vid_gnt(rr_vid_gnt), .vid_ack(rr_vid_ack),
        .aud_req(rr_aud_req), .aud_data(rr_aud_data), .aud_last(rr_aud_last), .aud_gnt(rr_aud_gnt), .aud_ack(rr_aud_ack),
        .txd(rr_txd), .tx_en(rr_tx_en), .busy(rr_busy), .trunc_err(rr_trunc)
    );

    crc32_d8 u_crc_chk (.crc_in(c_in), .d(c_d), .crc_out(c_out));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] vid_byte(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] aud_byte(input int i);
        return 8'(i) ^ 8'hA0;
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = (r[0] ^ b[k]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input int n, input bit is_vid);
        if (i < 7) return 8'h55;
        if (i == 7) return 8'hD5;
        if (i - 8 < n) return is_vid ? vid_byte(i - 8) : aud_byte(i - 8);
        return 8'h00;
    endfunction

    // Source models: react just after each rising edge, one byte per ack.
    int   vid_pend = 0, aud_pend = 0, vid_idx = 0, aud_idx = 0;
    int   vid_len = 0, aud_len = 0, vid_acks = 0, aud_acks = 0;
    bit   vid_nolast = 1'b0;
    logic vid_gnt_p = 1'b0, aud_gnt_p = 1'b0;

    initial begin
        vid_req = 1'b0; vid_data = 8'h00; vid_last = 1'b0;
        aud_req = 1'b0; aud_data = 8'h00; aud_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (vid_gnt && !vid_gnt_p) begin vid_idx = 0; if (vid_pend > 0) vid_pend--; end
            if (aud_gnt && !aud_gnt_p) begin aud_idx = 0; if (aud_pend > 0) aud_pend--; end
            vid_gnt_p = vid_gnt;
            aud_gnt_p = aud_gnt;
            vid_req = (vid_pend > 0);
            aud_req = (aud_pend > 0);
            if (vid_ack) begin
                vid_data = vid_byte(vid_idx);
                vid_last = !vid_nolast && (vid_idx == vid_len - 1);
                vid_idx++;
                vid_acks++;
            end
            if (aud_ack) begin
                aud_data = aud_byte(aud_idx);
                aud_last = (aud_idx == aud_len - 1);
                aud_idx++;
                aud_acks++;
            end
        end
    end

    // Wire monitor for the priority instance.
    logic [7:0] cur[$], last_frame[$];
    int   fl_len[$], fl_own[$], fl_gap[$];
    int   idle_cnt = 1000, own = 0, trunc_cnt = 0, frames_done = 0;
    bit   in_frm = 1'b0;
    logic gnt_last = 1'b0, gnt_after = 1'b0;

    initial forever begin
        @(negedge clk);
        if (trunc_err) trunc_cnt++;
        if (tx_en) begin
            if (!in_frm) begin
                in_frm = 1'b1;
                cur.delete();
                own = vid_gnt ? 1 : (aud_gnt ? 2 : 0);
                fl_gap.push_back(idle_cnt);
            end
            cur.push_back(txd);
            gnt_last = vid_gnt | aud_gnt;
        end else begin
            if (in_frm) begin
                in_frm = 1'b0;
                last_frame = cur;
                fl_len.push_back(cur.size());
                fl_own.push_back(own);
                gnt_after = vid_gnt | aud_gnt;
                frames_done++;
                idle_cnt = 0;
            end
            idle_cnt++;
        end
    end

    // Grant-order recorder for the round-robin instance: 0 = video, 1 = audio.
    logic [31:0] rr_seq = '0;
    int   rr_grants = 0;
    logic rr_v_p = 1'b0, rr_a_p = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rr_vid_gnt && !rr_v_p) begin rr_seq = rr_seq << 1; rr_grants++; end
        if (rr_aud_gnt && !rr_a_p) begin rr_seq = (rr_seq << 1) | 32'd1; rr_grants++; end
        rr_v_p = rr_vid_gnt;
        rr_a_p = rr_aud_gnt;
    end

    task automatic wait_frames(input int n, input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (frames_done < n && cyc < budget) begin nclk(); cyc++; end
        chk(tag, frames_done, n);
    endtask

    task automatic chk_frame(input string tag, input int n, input bit is_vid, input bit good_fcs);
        int exp_len, errs;
        logic [31:0] c_dat, c_all, fcs;
        exp_len = 12 + ((n < 60) ? 60 : n);
        errs = 0;
        c_dat = 32'hFFFFFFFF;
        c_all = 32'hFFFFFFFF;
        fcs = '0;
        chk({tag, "_len"}, last_frame.size(), exp_len);
        for (int i = 0; i < last_frame.size(); i++) begin
            if (i >= 8) c_all = crc_upd(c_all, last_frame[i]);
            if (i < exp_len - 4) begin
                if (i >= 8) c_dat = crc_upd(c_dat, last_frame[i]);
                if (last_frame[i] !== exp_byte(i, n, is_vid)) errs++;
            end else if (i < exp_len) begin
                fcs[8 * (i - exp_len + 4) +: 8] = last_frame[i];
            end
        end
        chk({tag, "_bytes"}, errs, 0);
        chk({tag, "_fcs"}, fcs, good_fcs ? ~c_dat : c_dat);
        chk({tag, "_residue_ok"}, {31'd0, c_all == CRC_RESIDUE}, {31'd0, good_fcs});
    endtask

    initial begin
        string s;
        int base, cyc, lows;
        sys_rst = 1'b1;
        rr_vid_req = 1'b0;
        rr_aud_req = 1'b0;
        c_in = 32'hFFFFFFFF;
        c_d = 8'h00;
        repeat (3) nclk();

        chk("rst_txd", txd, 8'h00);
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_vid_gnt", vid_gnt, 1'b0);
        chk("rst_aud_gnt", aud_gnt, 1'b0);
        chk("rst_acks", {vid_ack, aud_ack}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_trunc", trunc_err, 1'b0);
        sys_rst = 1'b0;
        nclk();

        s = "123456789";
        for (int i = 0; i < 9; i++) begin
            c_d = s[i];
            #1;
            c_in = c_out;
        end
        chk("crc_check_value", ~c_in, 32'hCBF43926);

        // Video-only 100-byte frame, with request-to-preamble latency.
        base = frames_done;
        vid_len = 100; vid_acks = 0; trunc_cnt = 0; vid_pend = 1;
        cyc = 0;
        while (!vid_req && cyc < 10) begin nclk(); cyc++; end
        chk("req_up", vid_req, 1'b1);
        nclk();
        chk("lat_vid_gnt", vid_gnt, 1'b1);
        chk("lat_tx_en", tx_en, 1'b1);
        chk("lat_txd", txd, 8'h55);
        chk("lat_busy", busy, 1'b1);
        wait_frames(base + 1, 300, "vid100_done");
        chk_frame("vid100", 100, 1'b1, 1'b1);
        chk("vid100_acks", vid_acks, 100);
        chk("vid100_owner", fl_own[base], 1);
        chk("vid100_gnt_last", gnt_last, 1'b1);
        chk("vid100_gnt_after", gnt_after, 1'b0);
        lows = 0;
        repeat (12) begin if (!tx_en) lows++; nclk(); end
        chk("vid100_ifg", lows, 12);
        chk("vid100_no_trunc", trunc_cnt, 0);

        // 20-byte audio frame padded to minimum length.
        base = frames_done;
        aud_len = 20; aud_acks = 0; aud_pend = 1;
        wait_frames(base + 1, 300, "aud20_done");
        chk_frame("aud20", 20, 1'b0, 1'b1);
        chk("aud20_acks", aud_acks, 20);
        chk("aud20_owner", fl_own[base], 2);

        // Simultaneous requests, audio priority, back-to-back gap.
        repeat (20) nclk();
        base = frames_done;
        aud_len = 30; vid_len = 60;
        aud_pend = 1; vid_pend = 1;
        wait_frames(base + 2, 500, "prio_done");
        chk("prio_first_owner", fl_own[base], 2);
        chk("prio_second_owner", fl_own[base + 1], 1);
        chk("prio_gap", fl_gap[base + 1], 12);
        chk_frame("prio_vid", 60, 1'b1, 1'b1);

        // Video never asserts last: truncation.
        repeat (20) nclk();
        base = frames_done;
        vid_nolast = 1'b1; vid_len = 0; vid_acks = 0; trunc_cnt = 0; vid_pend = 1;
        wait_frames(base + 1, 2000, "trunc_done");
        chk("trunc_acks", vid_acks, 1514);
        chk("trunc_pulses", trunc_cnt, 1);
        chk("trunc_gnt_last", gnt_last, 1'b1);
        chk("trunc_gnt_after", gnt_after, 1'b0);
        chk_frame("trunc", 1514, 1'b1, 1'b0);
        vid_nolast = 1'b0;

        // Reset in the middle of data, then a clean 64-byte frame.
        repeat (20) nclk();
        vid_len = 100; vid_acks = 0; vid_pend = 1;
        cyc = 0;
        while (vid_acks < 30 && cyc < 100) begin nclk(); cyc++; end
        chk("mid_rst_reach", vid_acks, 30);
        sys_rst = 1'b1;
        nclk();
        chk("mid_rst_tx_en", tx_en, 1'b0);
        chk("mid_rst_gnts", {vid_gnt, aud_gnt}, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_txd", txd, 8'h00);
        chk("mid_rst_ack", vid_ack, 1'b0);
        sys_rst = 1'b0;
        repeat (3) nclk();
        base = frames_done;
        vid_len = 64; vid_acks = 0; vid_pend = 1;
        wait_frames(base + 1, 300, "post_rst_done");
        chk_frame("post_rst", 64, 1'b1, 1'b1);

        // Round-robin instance: both held for four grants.
        rr_vid_req = 1'b1;
        rr_aud_req = 1'b1;
        cyc = 0;
        while (rr_grants < 4 && cyc < 600) begin nclk(); cyc++; end
        rr_vid_req = 1'b0;
        rr_aud_req = 1'b0;
        chk("rr_grants", rr_grants, 4);
        chk("rr_order", rr_seq, 32'h5);
        repeat (120) nclk();
        chk("rr_idle_busy", rr_busy, 1'b0);
        chk("rr_idle_tx", {rr_tx_en, rr_txd}, 9'd0);
        chk("rr_idle_misc", {rr_vid_ack, rr_aud_ack, rr_trunc}, 3'd0);
        chk("rr_total_grants", rr_grants, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gmii_tx_arb.md
# gmii_tx_arb

Transmit-side controller that shares one GMII transmit port between two frame sources: the video packet builder and the audio/aux packet builder. It arbitrates at frame boundaries and frames each payload on the wire with preamble, SFD, minimum-length padding, FCS and inter-frame gap. Requesters supply only the Ethernet header and payload bytes; GMII cannot stall, so each granted requester must supply one byte per cycle on demand.

## Interface
- `IFG_BYTES`, 12: idle cycles with `tx_en` low after each FCS.
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD.
- `MAX_FRAME`, 1514: maximum accepted bytes per frame, excluding FCS.
- `AUDIO_PRIO`, 1: 1 gives audio strict priority on a tie; 0 selects round-robin.

- `clk125`  in  1  GMII TX clock.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `vid_req`  in  1  video frame pending.
- `vid_data`  in  8  video byte; must be valid whenever `vid_ack` is high.
- `vid_last`  in  1  marks `vid_data` as the final byte.
- `vid_gnt`  out  1  video owns the port (PRE through FCS).
- `vid_ack`  out  1  video byte consumed at this edge.
- `aud_req`, `aud_data`, `aud_last`, `aud_gnt`, `aud_ack`: same as the video group, for audio.
- `txd`  out  8  GMII data.
- `tx_en`  out  1  GMII enable.
- `busy`  out  1  state is not IDLE.
- `trunc_err`  out  1  one-cycle pulse when a frame is truncated at `MAX_FRAME`.

## Operation
- States: IDLE → PRE → SFD → DATA → (PAD) → FCS → IFG → IDLE.
- IDLE:
  - `req` is sampled only in IDLE; a `req` change after grant is ignored.
  - If either `req` is high, latch the winner, set its `gnt`, and go to PRE.
  - Tie handling:
    - With `AUDIO_PRIO`=1, audio wins.
    - Otherwise the source not granted last wins. `last_grant` resets to audio, so video wins the first tie.
- PRE: `txd`=0x55 for `PREAMBLE_LEN` cycles.
- SFD: `txd`=0xD5. CRC is initialised to 0xFFFFFFFF. Byte counter is cleared.
- DATA:
  - `ack` = (state==DATA) & `gnt`; it is combinational from registered state.
  - Each edge with `ack` high latches `data` into `txd`, updates the CRC, and increments the 11-bit byte count.
  - `last` accepted with count+1 < 60: go to PAD.
  - `last` accepted otherwise: go to FCS.
- PAD: `txd`=0x00, included in the CRC, until the count reaches 60.
- Truncation:
  - Applies when the count reaches `MAX_FRAME` without `last`.
  - `ack` falls, `trunc_err` pulses, and the state goes to FCS with a corrupt flag set.
- FCS:
  - Sends 4 bytes of ~crc, least-significant byte first (reflected CRC, polynomial 0xEDB88320).
  - If the corrupt flag is set, the bytes sent are crc rather than ~crc, so the receiver's check fails.
  - `gnt` falls after the last FCS byte.
- IFG: `tx_en`=0 and `txd`=0 for `IFG_BYTES` cycles, then IDLE.

## Timing
- Reset values: `txd`=0, `tx_en`=0, `vid_gnt`/`aud_gnt`=0, acks=0, `busy`=0, `trunc_err`=0. State goes to IDLE, `last_grant` to audio, CRC to all-ones.
- Latency: `req` high at IDLE edge k gives `gnt`=1, `tx_en`=1 and `txd`=0x55 in cycle k+1.
- Handshake and ack timing:
  - `ack` is high in the cycle the SFD is on `txd`.
  - The byte sampled at that cycle's closing edge is on `txd` the next cycle.
  - Wire bytes are therefore contiguous: preamble, SFD, data, pad, FCS with no gaps.
- Frame length: `tx_en` is high for `PREAMBLE_LEN`+1+max(N,60)+4 cycles.
- Back-to-back frames:
  - The gap is exactly `IFG_BYTES` cycles between the last FCS byte and the next preamble, when `req` is already high on the IDLE edge.
  - IDLE lasts one cycle in that case.
- Requester may not stall. A byte not ready at `ack` is a requester bug; the arbiter sends whatever is on `data`.
- `sys_rst` asserted mid-frame: all outputs take reset values at the next edge. The frame is cut on the wire, which is acceptable; the receiver discards it on FCS.
- `last` and the truncation limit hit on the same edge: `last` wins, giving a normal FCS and no `trunc_err`.

## Structure
- Shared package/include `gmii_tx_pkg`: state encoding, 0x55, 0xD5, `MIN_FRAME`=60, CRC polynomial 0xEDB88320, residue 0xDEBB20E3.
- Sub-module `crc32_d8`:
  - Purpose: combinational next-CRC for 8-bit reflected input.
  - Ports: `crc_in`[31:0], `d`[7:0], `crc_out`[31:0].
  - The CRC register stays in `gmii_tx_arb`.

## Test plan
- `crc32_d8` fed ASCII "123456789" from 0xFFFFFFFF → final ~crc = 0xCBF43926.
- Video-only 100-byte frame → `tx_en` high 112 cycles: 7×0x55, 0xD5, 100 bytes, FCS. Reference-model CRC over data+FCS gives residue 0xDEBB20E3. At least 12 idle cycles follow.
- `vid_req` and `aud_req` high together:
  - `AUDIO_PRIO`=1: audio frame first; video preamble starts exactly 12 cycles after audio FCS.
  - `AUDIO_PRIO`=0, both held for 4 frames: grant order V,A,V,A.
- 20-byte audio frame → 40×0x00 pad bytes, `tx_en` high 72 cycles, FCS valid.
- Video source never asserts `last`:
  - Exactly 1514 acks, then `trunc_err` pulses once and `vid_gnt` falls after 4 FCS bytes.
  - FCS check fails.
- `sys_rst` pulsed at data byte 30 → next cycle `tx_en`=0, both `gnt`=0, `busy`=0. A following 64-byte frame transmits correctly.
